// File: rtl/move_commit.sv
// Commit stage for piece moves: latches a candidate placement and runs a request/done
// handshake with the collision checker. Legal candidates are committed; rejected drops lock the piece.
`ifndef BITS_X_POS
`define BITS_X_POS 4
`endif
`ifndef BITS_Y_POS
`define BITS_Y_POS 5
`endif
`ifndef BITS_ROT
`define BITS_ROT 2
`endif
`ifndef MODE_BITS
`define MODE_BITS 2
`endif
`ifndef MODE_PLAY
`define MODE_PLAY 2'd1
`endif

module move_commit #(
  parameter logic [`BITS_X_POS-1:0] SPAWN_X     = 4,
  parameter logic [`BITS_Y_POS-1:0] SPAWN_Y     = 0,
  parameter int                     CHK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`MODE_BITS-1:0]  mode,
  input  logic                   spawn_en,
  input  logic                   game_clk,
  input  logic                   btn_left_en,
  input  logic                   btn_right_en,
  input  logic                   btn_rotate_en,
  input  logic [`BITS_X_POS-1:0] test_pos_x,
  input  logic [`BITS_Y_POS-1:0] test_pos_y,
  input  logic [`BITS_ROT-1:0]   test_rot,
  output logic                   chk_req,
  output logic [`BITS_X_POS-1:0] chk_pos_x,
  output logic [`BITS_Y_POS-1:0] chk_pos_y,
  output logic [`BITS_ROT-1:0]   chk_rot,
  input  logic                   chk_done,
  input  logic                   chk_collide,
  output logic [`BITS_X_POS-1:0] cur_pos_x,
  output logic [`BITS_Y_POS-1:0] cur_pos_y,
  output logic [`BITS_ROT-1:0]   cur_rot,
  output logic                   busy,
  output logic                   piece_lock,
  output logic                   game_over
);

  localparam int CNT_W = $clog2(CHK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CHECK, LOCK} state_t;
  typedef enum logic [1:0] {KIND_SPAWN, KIND_DROP, KIND_SHIFT} kind_t;

  state_t             state, state_n;
  kind_t              kind;
  logic [CNT_W-1:0]   cnt;
  logic               play;
  logic               event_any;
  logic               timeout;
  logic               do_latch;
  logic               do_commit;
  logic               set_over;

  assign play      = (mode == `MODE_PLAY);
  assign event_any = spawn_en | game_clk | btn_left_en | btn_right_en | btn_rotate_en;
  assign timeout   = (cnt == CNT_W'(CHK_TIMEOUT - 1));

  assign chk_req = (state == CHECK);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A timeout without chk_done resolves exactly like a reported collision.
  always_comb begin
    state_n    = state;
    do_latch   = 1'b0;
    do_commit  = 1'b0;
    set_over   = 1'b0;
    piece_lock = 1'b0;
    case (state)
      IDLE: begin
        if (play && event_any) begin
          do_latch = 1'b1;
          state_n  = CHECK;
        end
      end
      CHECK: begin
        if (!play) begin
          state_n = IDLE;
        end else if (chk_done && !chk_collide) begin
          do_commit = 1'b1;
          state_n   = IDLE;
        end else if (chk_done || timeout) begin
          case (kind)
            KIND_DROP:  state_n = LOCK;
            KIND_SPAWN: begin
              do_commit = 1'b1;
              set_over  = 1'b1;
              state_n   = IDLE;
            end
            default:    state_n = IDLE;
          endcase
        end
      end
      LOCK: begin
        piece_lock = play;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Candidate capture, priority spawn > drop > shift; spawn ignores the test inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind      <= KIND_SHIFT;
      chk_pos_x <= '0;
      chk_pos_y <= '0;
      chk_rot   <= '0;
      cnt       <= '0;
    end else if (do_latch) begin
      cnt <= '0;
      if (spawn_en) begin
        kind      <= KIND_SPAWN;
        chk_pos_x <= SPAWN_X;
        chk_pos_y <= SPAWN_Y;
        chk_rot   <= '0;
      end else begin
        kind      <= game_clk ? KIND_DROP : KIND_SHIFT;
        chk_pos_x <= test_pos_x;
        chk_pos_y <= test_pos_y;
        chk_rot   <= test_rot;
      end
    end else if (state == CHECK) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_pos_x <= SPAWN_X;
      cur_pos_y <= SPAWN_Y;
      cur_rot   <= '0;
      game_over <= 1'b0;
    end else begin
      game_over <= set_over;
      if (do_commit) begin
        cur_pos_x <= chk_pos_x;
        cur_pos_y <= chk_pos_y;
        cur_rot   <= chk_rot;
      end
    end
  end

endmodule
